// File: rtl/pe_array_id_loader_pkg.sv
// rtl/pe_array_id_loader_pkg.sv - shared FSM state, network codes and unused-ID markers for the ID loader
package pe_array_id_loader_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEND_Y = 2'd1,
        S_SEND_X = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [1:0] NET_FILTER = 2'd0;
    localparam logic [1:0] NET_IFMAP  = 2'd1;
    localparam logic [1:0] NET_IPSUM  = 2'd2;
    localparam logic [1:0] NET_OPSUM  = 2'd3;

    // Same never-match encodings the ID generator emits for unused controllers.
    localparam logic [4:0] XID_UNUSED = 5'h1F;
    localparam logic [2:0] YID_UNUSED = 3'h7;

endpackage

// File: rtl/pe_array_id_loader_if.sv
// rtl/pe_array_id_loader_if.sv - valid/ready config bus into the per-PE and per-row multicast controllers
interface pe_array_id_loader_if #(
    parameter int XID_W = 5
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_net;
    logic             cfg_is_y;
    logic [2:0]       cfg_row;
    logic [3:0]       cfg_col;
    logic [XID_W-1:0] cfg_id;

    modport master (
        output cfg_valid, cfg_net, cfg_is_y, cfg_row, cfg_col, cfg_id,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_net, cfg_is_y, cfg_row, cfg_col, cfg_id,
        output cfg_ready
    );
endinterface

// File: rtl/pe_array_id_loader_id_scan_counter.sv
// rtl/pe_array_id_loader_id_scan_counter.sv - net/row/col walk over the ID snapshot; ID_LOADER_SKIP_UNUSED_EN adds next-used search
module id_scan_counter
    import pe_array_id_loader_pkg::*;
#(
    parameter int NUM_ROWS = 6,
    parameter int NUM_COLS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       step,
`ifdef ID_LOADER_SKIP_UNUSED_EN
    input  logic [4*(NUM_ROWS+NUM_ROWS*NUM_COLS)-1:0] used,
`endif
    output logic [1:0] net,
    output logic       is_y,
    output logic [2:0] row,
    output logic [3:0] col,
    output logic       nxt_live,
    output logic       nxt_is_y
);

    logic [1:0] net_q, net_d;
    logic       is_y_q, is_y_d;
    logic [2:0] row_q, row_d;
    logic [3:0] col_q, col_d;

`ifdef ID_LOADER_SKIP_UNUSED_EN
    localparam int STRIDE = NUM_ROWS + NUM_ROWS * NUM_COLS;

    int   cand;
    logic found;

    // Entries are ordered per network as Y rows then X row-major; search from the
    // successor of the current entry so the next presented entry is always a used one.
    always_comb begin
        net_d  = net_q;
        is_y_d = is_y_q;
        row_d  = row_q;
        col_d  = col_q;
        found  = 1'b0;
        cand   = load ? 0
               : int'(net_q) * STRIDE
                 + (is_y_q ? int'(row_q) : NUM_ROWS + int'(row_q) * NUM_COLS + int'(col_q)) + 1;
        if (load || step) begin
            for (int s = 0; s < 4 * STRIDE; s++) begin
                if (!found && s >= cand && used[s]) begin
                    found = 1'b1;
                    net_d = 2'(s / STRIDE);
                    if ((s % STRIDE) < NUM_ROWS) begin
                        is_y_d = 1'b1;
                        row_d  = 3'(s % STRIDE);
                        col_d  = 4'd0;
                    end else begin
                        is_y_d = 1'b0;
                        row_d  = 3'(((s % STRIDE) - NUM_ROWS) / NUM_COLS);
                        col_d  = 4'(((s % STRIDE) - NUM_ROWS) % NUM_COLS);
                    end
                end
            end
        end
        nxt_live = found;
    end
`else
    localparam logic [2:0] ROW_LAST = 3'(NUM_ROWS - 1);
    localparam logic [3:0] COL_LAST = 4'(NUM_COLS - 1);

    always_comb begin
        net_d    = net_q;
        is_y_d   = is_y_q;
        row_d    = row_q;
        col_d    = col_q;
        nxt_live = 1'b1;
        if (load) begin
            net_d  = NET_FILTER;
            is_y_d = 1'b1;
            row_d  = 3'd0;
            col_d  = 4'd0;
        end else if (step) begin
            if (is_y_q) begin
                if (row_q == ROW_LAST) begin
                    is_y_d = 1'b0;
                    row_d  = 3'd0;
                    col_d  = 4'd0;
                end else begin
                    row_d = row_q + 3'd1;
                end
            end else if (col_q != COL_LAST) begin
                col_d = col_q + 4'd1;
            end else begin
                col_d = 4'd0;
                if (row_q != ROW_LAST) begin
                    row_d = row_q + 3'd1;
                end else if (net_q == NET_OPSUM) begin
                    nxt_live = 1'b0;
                end else begin
                    net_d  = net_q + 2'd1;
                    is_y_d = 1'b1;
                    row_d  = 3'd0;
                end
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            net_q  <= '0;
            is_y_q <= 1'b0;
            row_q  <= '0;
            col_q  <= '0;
        end else begin
            net_q  <= net_d;
            is_y_q <= is_y_d;
            row_q  <= row_d;
            col_q  <= col_d;
        end
    end

    assign net      = net_q;
    assign is_y     = is_y_q;
    assign row      = row_q;
    assign col      = col_q;
    assign nxt_is_y = is_y_d;

endmodule

// File: rtl/pe_array_id_loader.sv
// rtl/pe_array_id_loader.sv - snapshots generated PE-array IDs and streams them over the config bus; ID_LOADER_SKIP_UNUSED_EN skips unused IDs
module pe_array_id_loader
    import pe_array_id_loader_pkg::*;
#(
    parameter int NUM_ROWS = 6,
    parameter int NUM_COLS = 8,
    parameter int XID_W    = 5,
    parameter int YID_W    = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             abort,
    input  logic [NUM_ROWS*NUM_COLS*XID_W-1:0] filter_xid_flat,
    input  logic [NUM_ROWS*YID_W-1:0]          filter_yid_flat,
    input  logic [NUM_ROWS*NUM_COLS*XID_W-1:0] ifmap_xid_flat,
    input  logic [NUM_ROWS*YID_W-1:0]          ifmap_yid_flat,
    input  logic [NUM_ROWS*NUM_COLS*XID_W-1:0] ipsum_xid_flat,
    input  logic [NUM_ROWS*YID_W-1:0]          ipsum_yid_flat,
    input  logic [NUM_ROWS*NUM_COLS*XID_W-1:0] opsum_xid_flat,
    input  logic [NUM_ROWS*YID_W-1:0]          opsum_yid_flat,
    pe_array_id_loader_if.master             cfg,
    output logic                             busy,
    output logic                             done
);

    localparam int NX = NUM_ROWS * NUM_COLS;

    state_t state_q, state_d;
    logic [3:0][NX*XID_W-1:0]       snap_x_q, snap_x_d, in_x;
    logic [3:0][NUM_ROWS*YID_W-1:0] snap_y_q, snap_y_d, in_y;

    logic       sending, hs, load;
    logic [1:0] net;
    logic       is_y, nxt_live, nxt_is_y;
    logic [2:0] row;
    logic [3:0] col;

    assign in_x = {opsum_xid_flat, ipsum_xid_flat, ifmap_xid_flat, filter_xid_flat};
    assign in_y = {opsum_yid_flat, ipsum_yid_flat, ifmap_yid_flat, filter_yid_flat};

    assign sending = (state_q == S_SEND_Y) || (state_q == S_SEND_X);
    assign hs      = sending && cfg.cfg_ready;
    assign load    = (state_q == S_IDLE) && start && !abort;

`ifdef ID_LOADER_SKIP_UNUSED_EN
    localparam int STRIDE = NUM_ROWS + NX;

    logic [3:0][NX*XID_W-1:0]       scan_x;
    logic [3:0][NUM_ROWS*YID_W-1:0] scan_y;
    logic [4*STRIDE-1:0]            used;

    // At start the snapshot is not loaded yet, so the first search looks at the live inputs.
    always_comb begin
        scan_x = (state_q == S_IDLE) ? in_x : snap_x_q;
        scan_y = (state_q == S_IDLE) ? in_y : snap_y_q;
        used   = '0;
        for (int n = 0; n < 4; n++) begin
            for (int r = 0; r < NUM_ROWS; r++)
                used[n*STRIDE + r] = (scan_y[n][r*YID_W +: YID_W] != YID_UNUSED);
            for (int i = 0; i < NX; i++)
                used[n*STRIDE + NUM_ROWS + i] = (scan_x[n][i*XID_W +: XID_W] != XID_UNUSED);
        end
    end
`endif

    id_scan_counter #(
        .NUM_ROWS (NUM_ROWS),
        .NUM_COLS (NUM_COLS)
    ) u_scan (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (hs),
`ifdef ID_LOADER_SKIP_UNUSED_EN
        .used     (used),
`endif
        .net      (net),
        .is_y     (is_y),
        .row      (row),
        .col      (col),
        .nxt_live (nxt_live),
        .nxt_is_y (nxt_is_y)
    );

    always_comb begin
        snap_x_d = load ? in_x : snap_x_q;
        snap_y_d = load ? in_y : snap_y_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            snap_x_q <= '0;
            snap_y_q <= '0;
        end else begin
            state_q  <= state_d;
            snap_x_q <= snap_x_d;
            snap_y_q <= snap_y_d;
        end
    end

    // A handshake coinciding with abort still advances the counter; abort only forces IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (load)
                    state_d = nxt_live ? (nxt_is_y ? S_SEND_Y : S_SEND_X) : S_DONE;
            end
            S_SEND_Y, S_SEND_X: begin
                if (abort)
                    state_d = S_IDLE;
                else if (hs)
                    state_d = nxt_live ? (nxt_is_y ? S_SEND_Y : S_SEND_X) : S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cfg.cfg_valid = sending;
        cfg.cfg_net   = '0;
        cfg.cfg_is_y  = 1'b0;
        cfg.cfg_row   = '0;
        cfg.cfg_col   = '0;
        cfg.cfg_id    = '0;
        busy          = sending;
        done          = (state_q == S_DONE);
        if (sending) begin
            cfg.cfg_net  = net;
            cfg.cfg_is_y = is_y;
            cfg.cfg_row  = row;
            if (is_y) begin
                cfg.cfg_id = {{(XID_W-YID_W){1'b0}}, snap_y_q[net][int'(row)*YID_W +: YID_W]};
            end else begin
                cfg.cfg_col = col;
                cfg.cfg_id  = snap_x_q[net][(int'(row)*NUM_COLS + int'(col))*XID_W +: XID_W];
            end
        end
    end

endmodule

// File: tb/tb_pe_array_id_loader.sv
// tb/tb_pe_array_id_loader.sv - self-checking bench for pe_array_id_loader against a transfer-list model
module tb_pe_array_id_loader;
    import pe_array_id_loader_pkg::*;

    localparam int NR = 6;
    localparam int NC = 8;
    localparam int XW = 5;
    localparam int YW = 3;
    localparam int NX = NR * NC;

    typedef struct packed {
        logic [1:0] net;
        logic       is_y;
        logic [2:0] row;
        logic [3:0] col;
        logic [4:0] id;
    } xfer_t;

    logic clk = 1'b0;
    logic rst, start, abort;
    logic [3:0][NX*XW-1:0] x_flat;
    logic [3:0][NR*YW-1:0] y_flat;
    logic busy, done;

    int n_checks = 0;
    int n_fail   = 0;
    xfer_t exp_q[$];

    pe_array_id_loader_if #(.XID_W(XW)) cfg ();

    pe_array_id_loader #(
        .NUM_ROWS (NR),
        .NUM_COLS (NC),
        .XID_W    (XW),
        .YID_W    (YW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .filter_xid_flat (x_flat[NET_FILTER]),
        .filter_yid_flat (y_flat[NET_FILTER]),
        .ifmap_xid_flat  (x_flat[NET_IFMAP]),
        .ifmap_yid_flat  (y_flat[NET_IFMAP]),
        .ipsum_xid_flat  (x_flat[NET_IPSUM]),
        .ipsum_yid_flat  (y_flat[NET_IPSUM]),
        .opsum_xid_flat  (x_flat[NET_OPSUM]),
        .opsum_yid_flat  (y_flat[NET_OPSUM]),
        .cfg             (cfg),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic randomize_inputs();
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < NX; i++)
                x_flat[n][i*XW +: XW] = ($urandom_range(0, 7) == 0) ? XID_UNUSED : 5'($urandom);
            for (int r = 0; r < NR; r++)
                y_flat[n][r*YW +: YW] = ($urandom_range(0, 5) == 0) ? YID_UNUSED : 3'($urandom);
        end
    endtask

    // Expected stream: per network all row controllers, then every PE row-major.
    task automatic build_expected();
        xfer_t t;
        exp_q.delete();
        for (int n = 0; n < 4; n++) begin
            for (int r = 0; r < NR; r++) begin
                t.net = 2'(n); t.is_y = 1'b1; t.row = 3'(r); t.col = 4'd0;
                t.id  = {2'b00, y_flat[n][r*YW +: YW]};
`ifdef ID_LOADER_SKIP_UNUSED_EN
                if (t.id[2:0] != YID_UNUSED)
`endif
                exp_q.push_back(t);
            end
            for (int r = 0; r < NR; r++) begin
                for (int c = 0; c < NC; c++) begin
                    t.net = 2'(n); t.is_y = 1'b0; t.row = 3'(r); t.col = 4'(c);
                    t.id  = x_flat[n][(r*NC + c)*XW +: XW];
`ifdef ID_LOADER_SKIP_UNUSED_EN
                    if (t.id != XID_UNUSED)
`endif
                    exp_q.push_back(t);
                end
            end
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
    endtask

    // pattern: 0 ready always, 1 ready 1,0,0 repeating, 2 random ready.
    // act_kind: 1 start while busy, 2 abort, 3 reset, 4 zero inputs after start, 5 start in DONE.
    task automatic stream(input int pattern, input int act_kind, input int act_at, input int max_cyc);
        int    k, xfers, last_k, exp_n;
        bit    fin, stalled, fired;
        logic  rdy;
        xfer_t obs, held, exp_t;
        k = 0; xfers = 0; last_k = 0; exp_n = exp_q.size();
        fin = 1'b0; stalled = 1'b0; held = '0;
        while (!fin) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            obs = {cfg.cfg_net, cfg.cfg_is_y, cfg.cfg_row, cfg.cfg_col, cfg.cfg_id};
            if (done) begin
                check("done_after_last", k, last_k + 1);
                check("done_left", exp_q.size(), 0);
                check("done_valid_busy", {cfg.cfg_valid, busy}, 0);
                if (pattern == 0) check("done_latency", k, exp_n + 1);
                if (act_kind == 5) begin
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                    check("start_in_done", {cfg.cfg_valid, busy, done}, 0);
                end
                fin = 1'b1;
            end else if (k > max_cyc) begin
                check("timeout", done, 1);
                fin = 1'b1;
            end else begin
                check("busy", busy, 1);
                if (stalled) check("hold", {cfg.cfg_valid, obs}, {1'b1, held});
                case (pattern)
                    0:       rdy = 1'b1;
                    1:       rdy = (k % 3 == 1);
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                fired = 1'b0;
                if (act_kind == 4 && k == 1) begin
                    x_flat = '0;
                    y_flat = '0;
                end
                if (cfg.cfg_valid && xfers == act_at) begin
                    case (act_kind)
                        1: begin start = 1'b1; randomize_inputs(); end
                        2: begin abort = 1'b1; rdy = 1'b1; fired = 1'b1; end
                        3: begin rst = 1'b1; rdy = 1'b0; fired = 1'b1; end
                        default: ;
                    endcase
                end
                cfg.cfg_ready = rdy;
                if (cfg.cfg_valid && rdy) begin
                    if (exp_q.size() == 0) begin
                        check("extra_xfer", xfers + 1, exp_n);
                    end else begin
                        exp_t = exp_q.pop_front();
                        check($sformatf("xfer%0d", xfers), obs, exp_t);
                    end
                    xfers++;
                    last_k = k;
                end
                stalled = cfg.cfg_valid && !rdy;
                held = obs;
                if (fired) begin
                    @(negedge clk);
                    abort = 1'b0;
                    rst = 1'b0;
                    cfg.cfg_ready = 1'b0;
                    if (act_kind == 3)
                        check("reset_mid_load", {cfg.cfg_valid, cfg.cfg_net, cfg.cfg_is_y, cfg.cfg_row,
                                                 cfg.cfg_col, cfg.cfg_id, busy, done}, 0);
                    else
                        check("abort_cut", {cfg.cfg_valid, busy, done}, 0);
                    for (int i = 0; i < 3; i++) begin
                        @(negedge clk);
                        check("idle_after_cut", {cfg.cfg_valid, busy, done}, 0);
                    end
                    fin = 1'b1;
                end
            end
        end
        start = 1'b0;
        cfg.cfg_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; cfg.cfg_ready = 1'b0;
        x_flat = '0; y_flat = '0;
        repeat (3) @(negedge clk);
        check("reset_state", {cfg.cfg_valid, cfg.cfg_net, cfg.cfg_is_y, cfg.cfg_row,
                              cfg.cfg_col, cfg.cfg_id, busy, done}, 0);
        rst = 1'b0;
        @(negedge clk);

        // basic load: filter X = i mod 32, every Y = row index, plus start in DONE cycle
        randomize_inputs();
        for (int i = 0; i < NX; i++) x_flat[NET_FILTER][i*XW +: XW] = 5'(i % 32);
        for (int n = 0; n < 4; n++)
            for (int r = 0; r < NR; r++) y_flat[n][r*YW +: YW] = 3'(r);
        build_expected();
        do_start();
        stream(0, 5, 0, 400);

        // backpressure, fixed then random
        randomize_inputs(); build_expected(); do_start(); stream(1, 0, 0, 1000);
        randomize_inputs(); build_expected(); do_start(); stream(2, 0, 0, 1500);

        // snapshot isolation
        randomize_inputs(); build_expected(); do_start(); stream(0, 4, 0, 400);

        // start while busy ignored
        randomize_inputs(); build_expected(); do_start(); stream(0, 1, 50, 400);

        // abort then fresh start
        randomize_inputs(); build_expected(); do_start(); stream(0, 2, 100, 400);
        randomize_inputs(); build_expected(); do_start(); stream(0, 0, 0, 400);

        // reset while stalled, then a load with random backpressure
        randomize_inputs(); build_expected(); do_start(); stream(1, 3, 30, 1000);
        randomize_inputs(); build_expected(); do_start(); stream(2, 0, 0, 1500);

        // mostly-unused ipsum/opsum maps
        randomize_inputs();
        for (int i = 0; i < NX; i++) begin
            x_flat[NET_IPSUM][i*XW +: XW] = (i < 6) ? 5'(i + 3) : XID_UNUSED;
            x_flat[NET_OPSUM][i*XW +: XW] = XID_UNUSED;
        end
        for (int r = 0; r < NR; r++) y_flat[NET_OPSUM][r*YW +: YW] = (r == 5) ? 3'd2 : YID_UNUSED;
        build_expected();
        do_start();
        stream(0, 0, 0, 400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
